// File: rtl/conv_acc_requant.sv
// Conv-layer accumulator: sums KERNEL_LEN signed products on a per-output bias, then requantizes to OUT_WIDTH.
// Optional ReLU on the requantized value is enabled by defining CONV_ACC_RELU_EN.
`timescale 1ns/1ps
module conv_acc_requant #(
  parameter int unsigned PROD_WIDTH = 24,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned KERNEL_LEN = 9,
  parameter int unsigned SHIFT      = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [PROD_WIDTH-1:0] prod_data,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  input  logic [ACC_WIDTH-1:0]  bias,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sat
);

  localparam int unsigned CNT_W = $clog2(KERNEL_LEN + 1);
  localparam logic signed [ACC_WIDTH-1:0] RND     = ACC_WIDTH'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  // Two's complement: the bitwise inverse of the positive limit is the negative limit.
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       count, count_n;
  logic signed [ACC_WIDTH-1:0] acc, acc_n;
  logic [OUT_WIDTH-1:0]   data_n;
  logic                   valid_n, sat_n, ready_n;

  logic signed [ACC_WIDTH-1:0] prod_ext, base, sum, rnd;
  logic [OUT_WIDTH-1:0]   q_data;
  logic                   q_sat;
  logic                   xfer, last;

  assign xfer = prod_valid && prod_ready;
  assign last = (count == CNT_W'(KERNEL_LEN - 1));

  // Next sum and its requantized value; the sum starts from bias on the first product of a window.
  always_comb begin
    prod_ext = {{(ACC_WIDTH - PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
    base     = (state == IDLE) ? bias : acc;
    sum      = base + prod_ext;
    rnd      = (sum + RND) >>> SHIFT;
`ifdef CONV_ACC_RELU_EN
    if (rnd < 0) rnd = '0;
`endif
    q_data = rnd[OUT_WIDTH-1:0];
    q_sat  = 1'b0;
    if (rnd > OUT_MAX) begin
      q_data = OUT_MAX[OUT_WIDTH-1:0];
      q_sat  = 1'b1;
    end else if (rnd < OUT_MIN) begin
      q_data = OUT_MIN[OUT_WIDTH-1:0];
      q_sat  = 1'b1;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n = state;
    count_n = count;
    acc_n   = acc;
    data_n  = out_data;
    valid_n = out_valid;
    sat_n   = out_sat;
    ready_n = prod_ready;
    unique case (state)
      IDLE, ACC: begin
        ready_n = 1'b1;
        if (xfer) begin
          acc_n   = sum;
          count_n = count + CNT_W'(1);
          if (last) begin
            state_n = EMIT;
            data_n  = q_data;
            sat_n   = q_sat;
            valid_n = 1'b1;
            ready_n = 1'b0;
          end else begin
            state_n = ACC;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_n = IDLE;
          count_n = '0;
          valid_n = 1'b0;
          ready_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= IDLE;
      count      <= '0;
      acc        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sat    <= 1'b0;
      prod_ready <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      acc        <= acc_n;
      out_data   <= data_n;
      out_valid  <= valid_n;
      out_sat    <= sat_n;
      prod_ready <= ready_n;
    end
  end

endmodule

// File: tb/tb_conv_acc_requant.sv
// Self-checking bench for conv_acc_requant: directed windows plus random traffic against a window-level model.
`timescale 1ns/1ps
module tb_conv_acc_requant;

  localparam int KLEN = 9;
  localparam int SH   = 8;

  logic        ap_clk, ap_rst_n;
  logic [23:0] prod_data;
  logic        prod_valid, prod_ready;
  logic [31:0] bias;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, out_sat;

  conv_acc_requant dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .prod_data  (prod_data),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .bias       (bias),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sat    (out_sat)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_vec = 0;
  int n_err = 0;

  // Model of what the outputs should show during the current cycle.
  logic       exp_ready, exp_valid, exp_sat, accepted;
  logic [7:0] exp_data;
  int         m_cnt;
  longint     m_sum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_out(input longint s);
    longint r;
    r = (s + (longint'(1) <<< (SH - 1))) >>> SH;
`ifdef CONV_ACC_RELU_EN
    if (r < 0) r = 0;
`endif
    exp_sat = 1'b0;
    if (r > 127) begin
      r = 127;
      exp_sat = 1'b1;
    end else if (r < -128) begin
      r = -128;
      exp_sat = 1'b1;
    end
    exp_data = 8'(r);
  endfunction

  function automatic void model_reset();
    exp_ready = 1'b0;
    exp_valid = 1'b0;
    exp_sat   = 1'b0;
    exp_data  = 8'h00;
    m_cnt     = 0;
    m_sum     = 0;
  endfunction

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic step(input logic pv, input logic [23:0] pd, input logic [31:0] bs, input logic ordy);
    @(negedge ap_clk);
    check("prod_ready", 32'(prod_ready), 32'(exp_ready));
    check("out_valid",  32'(out_valid),  32'(exp_valid));
    check("out_data",   32'(out_data),   32'(exp_data));
    check("out_sat",    32'(out_sat),    32'(exp_sat));
    prod_valid = pv;
    prod_data  = pd;
    bias       = bs;
    out_ready  = ordy;
    accepted   = exp_ready && pv;
    if (accepted) begin
      if (m_cnt == 0) m_sum = longint'($signed(bs)) + longint'($signed(pd));
      else            m_sum = m_sum + longint'($signed(pd));
      m_cnt++;
      if (m_cnt == KLEN) begin
        model_out(m_sum);
        exp_valid = 1'b1;
        m_cnt = 0;
      end
    end else if (exp_valid && ordy) begin
      exp_valid = 1'b0;
    end
    exp_ready = !exp_valid;
    @(posedge ap_clk);
  endtask

  // Present one window of identical products; b0 is the bias while waiting for the first accept.
  task automatic feed(input logic [23:0] p, input logic [31:0] b0, input logic [31:0] b1,
                      input bit bubbles, input logic ordy);
    int got = 0;
    for (int c = 0; c < 200 && got < KLEN; c++) begin
      step(bubbles ? logic'(c % 2 == 0) : 1'b1, p, (got == 0) ? b0 : b1, ordy);
      if (accepted) got++;
    end
    check("feed_count", 32'(got), 32'(KLEN));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 24'h0, 32'h0, 1'b1);
  endtask

  task automatic async_reset();
    @(negedge ap_clk);
    prod_valid = 1'b0;
    #2 ap_rst_n = 1'b0;
    #1;
    check("rst_out_valid",  32'(out_valid),  32'h0);
    check("rst_prod_ready", 32'(prod_ready), 32'h0);
    check("rst_out_data",   32'(out_data),   32'h0);
    #1 ap_rst_n = 1'b1;
    model_reset();
    @(posedge ap_clk);
    exp_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ap_rst_n   = 1'b0;
    prod_valid = 1'b0;
    prod_data  = '0;
    bias       = '0;
    out_ready  = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge ap_clk);
      check("reset_ready", 32'(prod_ready), 32'h0);
      check("reset_valid", 32'(out_valid),  32'h0);
      check("reset_data",  32'(out_data),   32'h0);
      check("reset_sat",   32'(out_sat),    32'h0);
    end
    #2 ap_rst_n = 1'b1;
    @(posedge ap_clk);
    exp_ready = 1'b1;

    feed(24'h000100, 32'd0, 32'd0, 1'b0, 1'b1);          // basic: 0x09
    drain(2);
    feed(24'h000000, 32'd128, 32'd128, 1'b0, 1'b1);      // rounds up to 0x01
    drain(2);
    feed(24'h000000, 32'(-129), 32'(-129), 1'b0, 1'b1);  // -1
    drain(2);
    feed(24'h7FFFFF, 32'd0, 32'd0, 1'b0, 1'b1);          // positive clip
    drain(2);
    feed(24'h800000, 32'd0, 32'd0, 1'b0, 1'b1);          // negative clip
    drain(2);
    feed(24'hFFFF80, 32'd0, 32'd0, 1'b0, 1'b1);          // -4, or 0 with ReLU
    drain(2);

    // Output held under backpressure while a new product waits.
    feed(24'h000100, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (5) step(1'b1, 24'h000200, 32'd0, 1'b0);
    feed(24'h000200, 32'd0, 32'd0, 1'b0, 1'b1);
    drain(2);

    // Bubbles; bias only taken with the first product.
    feed(24'h000100, 32'd256, 32'd9999, 1'b1, 1'b1);
    drain(2);

    // Reset part way through a window, then a clean window.
    for (int i = 0; i < 4; i++) step(1'b1, 24'h000100, 32'd0, 1'b1);
    async_reset();
    feed(24'h000100, 32'd0, 32'd0, 1'b0, 1'b1);
    drain(2);

    for (int i = 0; i < 400; i++)
      step(logic'($urandom_range(0, 3) != 0), 24'($urandom),
           32'(int'($urandom_range(0, 2097152)) - 1048576), logic'($urandom_range(0, 1)));
    drain(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
